// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   rsp_owner_e : who owns the read data returning next cycle
//   MEM_W_*     : access width codes (funct3[1:0])
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_owner_e;

   localparam logic [1:0] MEM_W_BYTE = 2'd0;
   localparam logic [1:0] MEM_W_HALF = 2'd1;
   localparam logic [1:0] MEM_W_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_store_lane.sv
// mem_store_lane: combinational byte-lane formatter for EX accesses.
//   width    in  2   access width code
//   off      in  2   byte offset (address[1:0])
//   data     in  32  right-aligned store data
//   wstrb    out 4   byte write strobes
//   wdata    out 32  data replicated across the active lanes
//   misalign out 1   access crosses its natural alignment (or bad width)
module mem_store_lane
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  off,
   input  logic [31:0] data,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misalign
);

   always_comb begin
      wstrb    = 4'b0000;
      wdata    = data;
      misalign = 1'b0;
      case (width)
         MEM_W_BYTE: begin
            wstrb = 4'b0001 << off;
            wdata = {4{data[7:0]}};
         end
         MEM_W_HALF: begin
            wstrb    = 4'b0011 << {off[1], 1'b0};
            wdata    = {2{data[15:0]}};
            misalign = off[0];
         end
         MEM_W_WORD: begin
            wstrb    = 4'b1111;
            misalign = (off != 2'b00);
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, 1-cycle-latency RAM between the
// fetch port (IF) and the EX load/store port.
//   clk, rst_n                 clock, async active-low reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata  fetch accept and returned instruction
//   d_load_en/d_store_en       EX requests; addresses, store data, width
//   d_gnt/d_rvalid/d_rdata     EX accept and right-aligned load data
//   d_misalign                 misaligned access dropped (1-cycle pulse)
//   mem_*                      RAM interface
//   stall_if/stall_ex          pipeline stall requests
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_load_en,
   input  logic          d_store_en,
   input  logic [AW-1:0] d_load_addr,
   input  logic [AW-1:0] d_store_addr,
   input  logic [31:0]   d_store_data,
   input  logic [1:0]    d_store_width,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          d_misalign,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wstrb,
   input  logic [31:0]   mem_rdata,
   output logic          stall_if,
   output logic          stall_ex
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW-1:0] WMASK = ~AW'(3);

   rsp_owner_e    rsp_owner;
   logic [CW-1:0] starve_cnt;
   logic [1:0]    off_q;
   logic          mis_q;

   logic          d_done, d_req, is_store, force_if, misalign, rd_d;
   logic [AW-1:0] d_addr;
   logic [3:0]    lane_strb;
   logic [31:0]   lane_wdata;

   // A load's response cycle is the only cycle d_done is set, so a still-held
   // completing load cannot be issued twice.
   assign d_done   = (rsp_owner == RSP_D);
   assign is_store = d_store_en;
   assign d_addr   = is_store ? d_store_addr : d_load_addr;
   assign d_req    = rst_n & (d_store_en | d_load_en) & ~d_done;
   assign force_if = (starve_cnt == CW'(STARVE_LIMIT));

   mem_store_lane u_lane (
      .width    (d_store_width),
      .off      (d_addr[1:0]),
      .data     (d_store_data),
      .wstrb    (lane_strb),
      .wdata    (lane_wdata),
      .misalign (misalign)
   );

   // EX has priority unless IF has been starved for STARVE_LIMIT grants.
   // Grants are masked by rst_n so every output is quiet while in reset.
   assign if_gnt     = rst_n & if_req & (~d_req | force_if);
   assign d_gnt      = d_req & ~if_gnt;
   assign d_misalign = d_gnt & misalign;
   assign rd_d       = d_gnt & ~is_store;

   assign mem_en    = if_gnt | (d_gnt & ~misalign);
   assign mem_we    = d_gnt & is_store & ~misalign;
   assign mem_addr  = if_gnt ? (if_addr & WMASK) : (mem_en ? (d_addr & WMASK) : '0);
   assign mem_wstrb = mem_we ? lane_strb  : 4'b0000;
   assign mem_wdata = mem_we ? lane_wdata : 32'h0;

   assign if_rvalid = (rsp_owner == RSP_IF);
   assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
   assign d_rvalid  = d_done;
   // A dropped misaligned load still completes, with zero data.
   assign d_rdata   = (d_rvalid && !mis_q) ? (mem_rdata >> {off_q, 3'b000}) : 32'h0;

   assign stall_if = rst_n & if_req & ~if_gnt;
   assign stall_ex = rst_n & (d_store_en ? ~d_gnt : (d_load_en & ~d_rvalid));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_owner  <= RSP_NONE;
         starve_cnt <= '0;
         off_q      <= 2'b00;
         mis_q      <= 1'b0;
      end else begin
         if (if_gnt)    rsp_owner <= RSP_IF;
         else if (rd_d) rsp_owner <= RSP_D;
         else           rsp_owner <= RSP_NONE;

         if (rd_d) begin
            off_q <= d_load_addr[1:0];
            mis_q <= misalign;
         end

         if (if_gnt || !if_req)
            starve_cnt <= '0;
         else if (d_gnt && !force_if)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_load_en = 1'b0, d_store_en = 1'b0;
   logic [31:0] d_load_addr = '0, d_store_addr = '0, d_store_data = '0;
   logic [1:0]  d_store_width = '0;
   logic        d_gnt, d_rvalid, d_misalign;
   logic [31:0] d_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic        stall_if, stall_ex;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_load_en(d_load_en), .d_store_en(d_store_en),
      .d_load_addr(d_load_addr), .d_store_addr(d_store_addr),
      .d_store_data(d_store_data), .d_store_width(d_store_width),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_misalign(d_misalign),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_ex(stall_ex)
   );

   typedef struct {
      logic        ifr;  logic [31:0] ia;
      logic        ld;   logic        st;
      logic [31:0] la;   logic [31:0] sa;  logic [31:0] sd;
      logic [1:0]  w;    logic [31:0] rd;
      logic        ig;   logic        dg;  logic en;  logic we;
      logic [31:0] addr; logic [3:0]  strb; logic [31:0] wd;
      logic        mis;  logic        sif; logic sex;
      logic        irv;  logic [31:0] ird;
      logic        drv;  logic [31:0] drd;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      if_req = 1'b0; d_load_en = 1'b0; d_store_en = 1'b0;
      if_addr = '0; d_load_addr = '0; d_store_addr = '0;
      d_store_data = '0; d_store_width = '0;
   endtask

   initial begin
      //        ifr ia      ld st la      sa      sd            w  rd
      //        ig dg en we addr   strb     wd            mis sif sex irv ird  drv drd
      vt[0]  = '{1, 32'h100, 0, 0, 32'h0,   32'h0,   32'h0,        2'd0, 32'h11223344,
                 1, 0, 1, 0, 32'h100, 4'b0000, 32'h0,        0, 0, 0, 1, 32'h11223344, 0, 32'h0};
      vt[1]  = '{0, 32'h0,   1, 0, 32'h204, 32'h0,   32'h0,        2'd2, 32'hCAFEF00D,
                 0, 1, 1, 0, 32'h204, 4'b0000, 32'h0,        0, 0, 1, 0, 32'h0, 1, 32'hCAFEF00D};
      vt[2]  = '{0, 32'h0,   1, 0, 32'h203, 32'h0,   32'h0,        2'd0, 32'hAABBCCDD,
                 0, 1, 1, 0, 32'h200, 4'b0000, 32'h0,        0, 0, 1, 0, 32'h0, 1, 32'h000000AA};
      vt[3]  = '{0, 32'h0,   0, 1, 32'h0,   32'h101, 32'h12,       2'd0, 32'h0,
                 0, 1, 1, 1, 32'h100, 4'b0010, 32'h12121212, 0, 0, 0, 0, 32'h0, 0, 32'h0};
      vt[4]  = '{0, 32'h0,   0, 1, 32'h0,   32'h102, 32'hBEEF,     2'd1, 32'h0,
                 0, 1, 1, 1, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 0, 0, 0, 32'h0, 0, 32'h0};
      vt[5]  = '{0, 32'h0,   0, 1, 32'h0,   32'h101, 32'h3344,     2'd1, 32'h0,
                 0, 1, 0, 0, 32'h0,   4'b0000, 32'h0,        1, 0, 0, 0, 32'h0, 0, 32'h0};
      vt[6]  = '{0, 32'h0,   1, 0, 32'h206, 32'h0,   32'h0,        2'd2, 32'hFFFFFFFF,
                 0, 1, 0, 0, 32'h0,   4'b0000, 32'h0,        1, 0, 1, 0, 32'h0, 1, 32'h0};
      vt[7]  = '{0, 32'h0,   1, 1, 32'h400, 32'h300, 32'h55AA55AA, 2'd2, 32'h99999999,
                 0, 1, 1, 1, 32'h300, 4'b1111, 32'h55AA55AA, 0, 0, 0, 0, 32'h0, 0, 32'h0};
      vt[8]  = '{1, 32'h40,  1, 0, 32'h10,  32'h0,   32'h0,        2'd2, 32'h0BADF00D,
                 0, 1, 1, 0, 32'h10,  4'b0000, 32'h0,        0, 1, 1, 0, 32'h0, 1, 32'h0BADF00D};
      vt[9]  = '{0, 32'h0,   1, 0, 32'h202, 32'h0,   32'h0,        2'd1, 32'h8001BEEF,
                 0, 1, 1, 0, 32'h200, 4'b0000, 32'h0,        0, 0, 1, 0, 32'h0, 1, 32'h00008001};
      vt[10] = '{0, 32'h0,   0, 1, 32'h0,   32'h100, 32'h1,        2'd3, 32'h0,
                 0, 1, 0, 0, 32'h0,   4'b0000, 32'h0,        1, 0, 0, 0, 32'h0, 0, 32'h0};
      vt[11] = '{0, 32'h0,   0, 1, 32'h0,   32'h104, 32'hDEADBEEF, 2'd2, 32'h0,
                 0, 1, 1, 1, 32'h104, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0, 32'h0};
      vt[12] = '{0, 32'h0,   0, 1, 32'h0,   32'h103, 32'h1A7,      2'd0, 32'h0,
                 0, 1, 1, 1, 32'h100, 4'b1000, 32'hA7A7A7A7, 0, 0, 0, 0, 32'h0, 0, 32'h0};

      // Reset: outputs quiet even with requests present.
      if_req = 1'b1; if_addr = 32'h100; d_load_en = 1'b1; d_store_width = 2'd2;
      #12;
      chk("rst if_gnt",   32'(if_gnt),   32'h0);
      chk("rst d_gnt",    32'(d_gnt),    32'h0);
      chk("rst mem_en",   32'(mem_en),   32'h0);
      chk("rst stall_if", 32'(stall_if), 32'h0);
      chk("rst stall_ex", 32'(stall_ex), 32'h0);
      chk("rst rvalid",   32'({if_rvalid, d_rvalid}), 32'h0);
      idle();
      @(negedge clk); rst_n = 1'b1;

      foreach (vt[i]) begin
         @(negedge clk);
         if_req = vt[i].ifr; if_addr = vt[i].ia;
         d_load_en = vt[i].ld; d_store_en = vt[i].st;
         d_load_addr = vt[i].la; d_store_addr = vt[i].sa;
         d_store_data = vt[i].sd; d_store_width = vt[i].w;
         #1;
         chk($sformatf("v%0d if_gnt", i),     32'(if_gnt),     32'(vt[i].ig));
         chk($sformatf("v%0d d_gnt", i),      32'(d_gnt),      32'(vt[i].dg));
         chk($sformatf("v%0d mem_en", i),     32'(mem_en),     32'(vt[i].en));
         chk($sformatf("v%0d mem_we", i),     32'(mem_we),     32'(vt[i].we));
         chk($sformatf("v%0d d_misalign", i), 32'(d_misalign), 32'(vt[i].mis));
         chk($sformatf("v%0d stall_if", i),   32'(stall_if),   32'(vt[i].sif));
         chk($sformatf("v%0d stall_ex", i),   32'(stall_ex),   32'(vt[i].sex));
         if (vt[i].en) chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].addr);
         if (vt[i].we) begin
            chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vt[i].strb));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].wd);
         end
         @(negedge clk);
         // Response cycle: a granted load is still held, as the pipeline would.
         if_req = 1'b0; d_store_en = 1'b0;
         d_load_en = vt[i].ld & ~vt[i].st;
         mem_rdata = vt[i].rd;
         #1;
         chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(vt[i].irv));
         chk($sformatf("v%0d d_rvalid", i),  32'(d_rvalid),  32'(vt[i].drv));
         if (vt[i].irv) chk($sformatf("v%0d if_rdata", i), if_rdata, vt[i].ird);
         if (vt[i].drv) chk($sformatf("v%0d d_rdata", i),  d_rdata,  vt[i].drd);
         chk($sformatf("v%0d rsp stall_ex", i), 32'(stall_ex), 32'h0);
         chk($sformatf("v%0d no reissue", i),   32'(mem_en | d_gnt), 32'h0);
         @(negedge clk);
         idle();
         mem_rdata = '0;
      end

      // Starvation: IF and a store both requesting every cycle.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h80;
      d_store_en = 1'b1; d_store_addr = 32'h10; d_store_width = 2'd2;
      d_store_data = 32'h01020304;
      for (int k = 0; k < 15; k++) begin
         #1;
         chk($sformatf("starve c%0d if_gnt", k), 32'(if_gnt), 32'((k % 5) == 4));
         chk($sformatf("starve c%0d d_gnt", k),  32'(d_gnt),  32'((k % 5) != 4));
         @(negedge clk);
      end
      idle();

      // Reset the cycle after a load grant: the response must be dropped.
      @(negedge clk);
      d_load_en = 1'b1; d_load_addr = 32'h20; d_store_width = 2'd2;
      #1;
      chk("rstmid d_gnt", 32'(d_gnt), 32'h1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid d_rvalid",  32'(d_rvalid), 32'h0);
      chk("rstmid outputs",   32'({if_gnt, d_gnt, mem_en, mem_we, stall_if, stall_ex,
                                   if_rvalid, d_misalign}), 32'h0);
      chk("rstmid mem_addr",  mem_addr, 32'h0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post-rst c%0d rvalid", k), 32'({if_rvalid, d_rvalid}), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
